// File: rtl/mux_arb_n.sv
// mux_arb_n: registered N-channel valid/ready multiplexer with built-in
// arbitration (fixed priority or round-robin) and a one-stage output register.
// Optional feature macro: MUX_ARB_LOCK_EN -- adds the lock input, which pins
// the grant to the channel currently shown on out_sel.
module mux_arb_n #(
  parameter int  WIDTH    = 16,
  parameter int  CHANNELS = 4,
  parameter int  RR       = 1,
  localparam int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SELW-1:0]           out_sel
`ifdef MUX_ARB_LOCK_EN
  ,
  input  logic                      lock
`endif
);

  logic [SELW-1:0]  r_ptr;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SELW-1:0]  r_out_sel;

  logic             w_load;
  logic [SELW-1:0]  w_start;
  logic             w_grant_vld;
  logic [SELW-1:0]  w_grant_idx;
  logic [SELW-1:0]  w_ptr_nxt;
  logic             w_locked;

  // The output register can take a new word when empty or being drained;
  // nothing is accepted while reset is asserted.
  assign w_load  = ~rst & (~r_out_valid | out_ready);

  // Fixed priority always searches from channel 0.
  assign w_start = (RR != 0) ? r_ptr : '0;

`ifdef MUX_ARB_LOCK_EN
  logic r_xfer_seen;

  // Lock only applies once out_sel names a channel that actually delivered.
  assign w_locked = lock & (r_out_valid | r_xfer_seen);

  // Remember that at least one transfer happened since reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer_seen <= 1'b0;
    end else if (w_load && w_grant_vld) begin
      r_xfer_seen <= 1'b1;
    end
  end
`else
  assign w_locked = 1'b0;
`endif

  // Search upward from the start index with explicit wrap, first valid wins.
  always_comb begin
    int idx;
    idx         = 0;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = int'(w_start) + k;
      if (idx >= CHANNELS) begin
        idx = idx - CHANNELS;
      end
      if (!w_grant_vld && in_valid[idx]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = idx[SELW-1:0];
      end
    end
`ifdef MUX_ARB_LOCK_EN
    if (w_locked) begin
      w_grant_idx = r_out_sel;
      w_grant_vld = in_valid[r_out_sel];
    end
`endif
  end

  // One-hot ready towards the granted producer, only when the register loads.
  always_comb begin
    in_ready = '0;
    if (w_load && w_grant_vld) begin
      in_ready[w_grant_idx] = 1'b1;
    end
  end

  // Pointer moves just past the winner; explicit wrap for non-power-of-2 counts.
  assign w_ptr_nxt = (w_grant_idx == SELW'(CHANNELS - 1)) ? '0 : w_grant_idx + 1'b1;

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else if (w_load) begin
      r_out_valid <= w_grant_vld;
      if (w_grant_vld) begin
        r_out_data <= in_data[w_grant_idx*WIDTH +: WIDTH];
        r_out_sel  <= w_grant_idx;
        if ((RR != 0) && !w_locked) begin
          r_ptr <= w_ptr_nxt;
        end
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux_arb_n.sv
// Bench for mux_arb_n: three instances (fixed priority x4, round-robin x4,
// round-robin x3) driven from one vector table plus reset and lock sequences.
module tb_mux_arb_n;

  typedef struct {
    int          dut;
    logic [3:0]  vld;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [15:0] exp_data;
    logic [1:0]  exp_sel;
  } vec_t;

  localparam logic [63:0] D4 = {16'h3333, 16'h2222, 16'h1111, 16'h0A0A};
  localparam logic [23:0] D3 = {8'hC2, 8'hB1, 8'hA0};

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  fp_valid, rr_valid;
  logic [2:0]  w3_valid;
  logic        fp_ordy, rr_ordy, w3_ordy;
  logic [3:0]  fp_rdy, rr_rdy;
  logic [2:0]  w3_rdy;
  logic [15:0] fp_out, rr_out;
  logic [7:0]  w3_out;
  logic        fp_ov, rr_ov, w3_ov;
  logic [1:0]  fp_sel, rr_sel, w3_sel;
`ifdef MUX_ARB_LOCK_EN
  logic        rr_lock = 1'b0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int n_vec  = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mux_arb_n #(.WIDTH(16), .CHANNELS(4), .RR(0)) u_fp (
    .clk(clk), .rst(rst), .in_data(D4), .in_valid(fp_valid), .in_ready(fp_rdy),
    .out_data(fp_out), .out_valid(fp_ov), .out_ready(fp_ordy), .out_sel(fp_sel)
`ifdef MUX_ARB_LOCK_EN
    , .lock(1'b0)
`endif
  );

  mux_arb_n #(.WIDTH(16), .CHANNELS(4), .RR(1)) u_rr (
    .clk(clk), .rst(rst), .in_data(D4), .in_valid(rr_valid), .in_ready(rr_rdy),
    .out_data(rr_out), .out_valid(rr_ov), .out_ready(rr_ordy), .out_sel(rr_sel)
`ifdef MUX_ARB_LOCK_EN
    , .lock(rr_lock)
`endif
  );

  mux_arb_n #(.WIDTH(8), .CHANNELS(3), .RR(1)) u_w3 (
    .clk(clk), .rst(rst), .in_data(D3), .in_valid(w3_valid), .in_ready(w3_rdy),
    .out_data(w3_out), .out_valid(w3_ov), .out_ready(w3_ordy), .out_sel(w3_sel)
`ifdef MUX_ARB_LOCK_EN
    , .lock(1'b0)
`endif
  );

  function automatic vec_t mk(int d, logic [3:0] vl, logic o, logic [3:0] r,
                              logic ov, logic [15:0] dt, logic [1:0] s);
    vec_t v;
    v.dut = d; v.vld = vl; v.ordy = o; v.exp_rdy = r;
    v.exp_ov = ov; v.exp_data = dt; v.exp_sel = s;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_all();
    fp_valid = '0; fp_ordy = 1'b0;
    rr_valid = '0; rr_ordy = 1'b0;
    w3_valid = '0; w3_ordy = 1'b0;
  endtask

  task automatic sample(input int d, output logic [3:0] rdy, output logic ov,
                        output logic [15:0] dat, output logic [1:0] sel);
    case (d)
      0:       begin rdy = fp_rdy; ov = fp_ov; dat = fp_out; sel = fp_sel; end
      1:       begin rdy = rr_rdy; ov = rr_ov; dat = rr_out; sel = rr_sel; end
      default: begin rdy = {1'b0, w3_rdy}; ov = w3_ov; dat = {8'h00, w3_out}; sel = w3_sel; end
    endcase
  endtask

  task automatic apply(input vec_t v);
    logic [3:0]  rdy;
    logic        ov;
    logic [15:0] dat;
    logic [1:0]  sel;
    n_vec++;
    @(negedge clk);
    idle_all();
    case (v.dut)
      0:       begin fp_valid = v.vld; fp_ordy = v.ordy; end
      1:       begin rr_valid = v.vld; rr_ordy = v.ordy; end
      default: begin w3_valid = v.vld[2:0]; w3_ordy = v.ordy; end
    endcase
    #1;
    sample(v.dut, rdy, ov, dat, sel);
    check($sformatf("v%0d_d%0d_in_ready", n_vec, v.dut), 32'(rdy), 32'(v.exp_rdy));
    @(posedge clk);
    #1;
    sample(v.dut, rdy, ov, dat, sel);
    check($sformatf("v%0d_d%0d_out_valid", n_vec, v.dut), 32'(ov), 32'(v.exp_ov));
    check($sformatf("v%0d_d%0d_out_data", n_vec, v.dut), 32'(dat), 32'(v.exp_data));
    check($sformatf("v%0d_d%0d_out_sel", n_vec, v.dut), 32'(sel), 32'(v.exp_sel));
  endtask

  task automatic reset_check(input int cycles, input string tag);
    logic [3:0]  rdy;
    logic        ov;
    logic [15:0] dat;
    logic [1:0]  sel;
    @(negedge clk);
    rst = 1'b1;
    fp_valid = 4'hF; fp_ordy = 1'b1;
    rr_valid = 4'hF; rr_ordy = 1'b1;
    w3_valid = 3'h7; w3_ordy = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      #1;
      for (int d = 0; d < 3; d++) begin
        sample(d, rdy, ov, dat, sel);
        check($sformatf("%s_c%0d_d%0d_in_ready", tag, c, d), 32'(rdy), 32'h0);
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        sample(d, rdy, ov, dat, sel);
        check($sformatf("%s_c%0d_d%0d_out_valid", tag, c, d), 32'(ov), 32'h0);
        check($sformatf("%s_c%0d_d%0d_out_data", tag, c, d), 32'(dat), 32'h0);
        check($sformatf("%s_c%0d_d%0d_out_sel", tag, c, d), 32'(sel), 32'h0);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    idle_all();
  endtask

  initial begin
    rst = 1'b1;
    idle_all();

    // Fixed priority, 4 channels (dut 0)
    vecs.push_back(mk(0, 4'b1010, 1'b1, 4'b0010, 1'b1, 16'h1111, 2'd1));
    vecs.push_back(mk(0, 4'b1010, 1'b1, 4'b0010, 1'b1, 16'h1111, 2'd1));
    vecs.push_back(mk(0, 4'b1010, 1'b0, 4'b0000, 1'b1, 16'h1111, 2'd1));
    vecs.push_back(mk(0, 4'b1000, 1'b1, 4'b1000, 1'b1, 16'h3333, 2'd3));
    vecs.push_back(mk(0, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h3333, 2'd3));
    vecs.push_back(mk(0, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'h3333, 2'd3));
    vecs.push_back(mk(0, 4'b1111, 1'b0, 4'b0001, 1'b1, 16'h0A0A, 2'd0));
    vecs.push_back(mk(0, 4'b1110, 1'b0, 4'b0000, 1'b1, 16'h0A0A, 2'd0));
    vecs.push_back(mk(0, 4'b1110, 1'b1, 4'b0010, 1'b1, 16'h1111, 2'd1));
    vecs.push_back(mk(0, 4'b0100, 1'b1, 4'b0100, 1'b1, 16'h2222, 2'd2));
    // Round-robin, 4 channels (dut 1): rotation, backpressure, release
    vecs.push_back(mk(1, 4'b1111, 1'b1, 4'b0001, 1'b1, 16'h0A0A, 2'd0));
    vecs.push_back(mk(1, 4'b1111, 1'b1, 4'b0010, 1'b1, 16'h1111, 2'd1));
    vecs.push_back(mk(1, 4'b1111, 1'b1, 4'b0100, 1'b1, 16'h2222, 2'd2));
    vecs.push_back(mk(1, 4'b1111, 1'b1, 4'b1000, 1'b1, 16'h3333, 2'd3));
    vecs.push_back(mk(1, 4'b1111, 1'b1, 4'b0001, 1'b1, 16'h0A0A, 2'd0));
    vecs.push_back(mk(1, 4'b1111, 1'b0, 4'b0000, 1'b1, 16'h0A0A, 2'd0));
    vecs.push_back(mk(1, 4'b1111, 1'b0, 4'b0000, 1'b1, 16'h0A0A, 2'd0));
    vecs.push_back(mk(1, 4'b1111, 1'b0, 4'b0000, 1'b1, 16'h0A0A, 2'd0));
    vecs.push_back(mk(1, 4'b1111, 1'b1, 4'b0010, 1'b1, 16'h1111, 2'd1));
    vecs.push_back(mk(1, 4'b0001, 1'b1, 4'b0001, 1'b1, 16'h0A0A, 2'd0));
    // Round-robin, 3 channels (dut 2): explicit wrap of the pointer
    vecs.push_back(mk(2, 4'b0111, 1'b1, 4'b0001, 1'b1, 16'h00A0, 2'd0));
    vecs.push_back(mk(2, 4'b0110, 1'b1, 4'b0010, 1'b1, 16'h00B1, 2'd1));
    vecs.push_back(mk(2, 4'b0100, 1'b1, 4'b0100, 1'b1, 16'h00C2, 2'd2));
    vecs.push_back(mk(2, 4'b0101, 1'b1, 4'b0001, 1'b1, 16'h00A0, 2'd0));
    vecs.push_back(mk(2, 4'b0101, 1'b1, 4'b0100, 1'b1, 16'h00C2, 2'd2));
    vecs.push_back(mk(2, 4'b0101, 1'b1, 4'b0001, 1'b1, 16'h00A0, 2'd0));
    vecs.push_back(mk(2, 4'b0010, 1'b0, 4'b0000, 1'b1, 16'h00A0, 2'd0));
    vecs.push_back(mk(2, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h00A0, 2'd0));

    reset_check(2, "por");

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      // Reset while the fixed-priority register holds a word
      if (i == 9) begin
        reset_check(1, "mid");
      end
    end

`ifdef MUX_ARB_LOCK_EN
    reset_check(1, "lck");
    apply(mk(1, 4'b0100, 1'b1, 4'b0100, 1'b1, 16'h2222, 2'd2));
    rr_lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(mk(1, 4'b1111, 1'b1, 4'b0100, 1'b1, 16'h2222, 2'd2));
    end
    rr_lock = 1'b0;
    apply(mk(1, 4'b1111, 1'b1, 4'b1000, 1'b1, 16'h3333, 2'd3));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_arb_n.md
# mux_arb_n

Parametrised, registered N-channel operand/bus multiplexer with valid/ready handshakes and built-in arbitration. It is the successor to the fixed 16-bit 2:1 select mux: any data width, any channel count, fixed-priority or round-robin selection, and a one-stage output register. It sits between multiple producers (register-file read ports, immediate path, memory read-back) and a single consumer stage on the CPU datapath.

## Interface
- WIDTH, 16, data width per channel in bits (≥1)
- CHANNELS, 4, number of input channels (≥2)
- RR, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
- SELW, derived = $clog2(CHANNELS), width of select/grant index (local parameter)

- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  channel i has data
- in_ready  output  CHANNELS  channel i's data is taken this cycle
- out_data  output  WIDTH  registered selected data
- out_valid  output  1  out_data holds a word
- out_ready  input  1  consumer accepts out_data
- out_sel  output  SELW  index of channel that supplied out_data
- lock  input  1  present only with MUX_ARB_LOCK_EN (see Configuration)

## Operation
- Load enable: load = ~out_valid | out_ready (pipeline register, no bubble).
- Grant (combinational): among channels with in_valid=1, pick one.
  - RR=0: lowest index wins.
  - RR=1: search starts at pointer ptr, ascending, wrapping CHANNELS-1 → 0; first valid wins.
- in_ready[i] = load & grant[i]; at most one bit high; zero when no channel valid.
- Transfer from channel g when in_valid[g] & in_ready[g]: out_data ← in_data[g], out_sel ← g, out_valid ← 1.
- load=1 with no valid channel: out_valid ← 0; out_data/out_sel hold.
- load=0 (out_valid=1, out_ready=0): all outputs hold, all in_ready=0.
- Pointer (RR=1 only): on transfer from g, ptr ← (g+1) mod CHANNELS; otherwise holds. Non-power-of-2 CHANNELS wrap explicitly, never index out of range.
- Channels not granted see in_ready=0 and must hold data/valid (standard valid/ready rules; valid never depends on ready).

## Timing
- Reset (rst=1 at clk edge): out_valid=0, out_data=0, out_sel=0, ptr=0; in_ready=0 during reset cycle. Reset mid-transfer discards the registered word.
- Latency: input accepted at edge N appears on out_data/out_valid after edge N.
- Throughput: one word per cycle while out_ready=1 and some input valid.
- Simultaneous out_ready=1 and new grant: old word consumed and new word loaded on same edge.
- in_ready is combinational from in_valid, out_valid, out_ready, ptr (and lock); out_* are registers only, no combinational input→output path.

## Configuration
- MUX_ARB_LOCK_EN defined: lock port exists. While lock=1 and out_valid=1 or a prior transfer has occurred, grant is restricted to channel out_sel; other channels get in_ready=0 even if valid; ptr does not advance. lock=0 restores normal arbitration next cycle.
- Not defined: no lock port; arbitration always per Operation.

## Test plan
- Reset: assert rst 2 cycles with all in_valid=1 → out_valid=0, out_data=0, out_sel=0, in_ready=0000.
- Fixed priority (RR=0, CHANNELS=4): in_valid=1010, data ch1=0x1111, ch3=0x3333, out_ready=1 → next cycle out_data=0x1111, out_sel=1; ch3 starved while ch1 valid.
- Round-robin (RR=1): all 4 channels valid continuously, out_ready=1 → out_sel sequence 0,1,2,3,0 on consecutive cycles, one word per cycle.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles → out_data stable, in_ready=0000; raise out_ready → held word consumed and next granted word loaded same edge.
- Wrap/non-power-of-2 (CHANNELS=3, RR=1): only ch2 and ch0 valid after grant to ch2 → next grant ch0, ptr wraps to 1.
- Lock (MUX_ARB_LOCK_EN): grant to ch2, assert lock, all channels valid → ch2 granted every cycle; deassert lock → next grant ch3.
